clock_sim_core: RTL and testbench
=================================

# clock_sim_core

Parametrised MM:SS clock/timer core for the clock simulator top level. It runs entirely in the `clk` domain using tick enables, with no derived clocks. It adds count-up and count-down modes, run/pause toggling, clear, and field adjustment with a blinking selected field. It drives a multiplexed 4-digit active-low seven-segment display. Button inputs arrive already debounced (level) from the existing debouncers.

## Interface
- `CLK_HZ`, default 100_000_000, input clock frequency. Must be divisible by 4 and by `SCAN_HZ`.
- `SCAN_HZ`, default 1000, digit-slot rate; each digit is held for `CLK_HZ/SCAN_HZ` cycles.
- `MAX_MIN`, default 59, highest minutes value, range 1..99.
- `MODE`, default 0. 0 = count up; 1 = count down (timer).

Ports:
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-low reset.
- `btn_pause` input 1: debounced level; a rising edge toggles run.
- `btn_clear` input 1: debounced level; a rising edge clears the time to 00:00.
- `sel_adj` input 1: level; 1 = adjust mode.
- `adj_field` input 1: 0 = adjust seconds, 1 = adjust minutes.
- `an` output 4: digit enables, active-low; `an[3]` = minutes tens … `an[0]` = seconds ones.
- `seg` output 7: segments a..g as `seg[6]..seg[0]`, active-low.
- `dp` output 1: decimal point, active-low.
- `running` output 1: run flag.
- `done` output 1: count-down expired flag.
- `min_bcd` output 8: minutes in BCD, tens in `[7:4]`.
- `sec_bcd` output 8: seconds in BCD, tens in `[7:4]`.

## Operation
- **Input conditioning:** `btn_pause` and `btn_clear` each pass through a 2-flop synchroniser, then a previous-value flop. The edge pulse is `sync & ~prev`.
- **Tick generation:**
  - A prescaler counts 0..`CLK_HZ/4`-1 and pulses `q_tick` on its terminal count.
  - A 2-bit phase counter advances on each `q_tick`.
  - `sec_tick` = `q_tick` when phase==3.
  - `adj_tick` = `q_tick` when phase[0]==1, giving 2 Hz.
  - `blink` toggles on every `q_tick`.
  - A clear edge resets the prescaler, the phase counter and `blink` to 0.
- **Priority order** (highest first): clear edge, adjust, pause edge, `sec_tick`.
- **Clear edge:** time becomes 00:00, `running`=0, `done`=0. This also applies when a pause edge arrives in the same cycle.
- **Adjust (`sel_adj`=1):**
  - Time does not advance.
  - Each `adj_tick` increments the selected field: seconds modulo 60, minutes modulo `MAX_MIN`+1. The increment applies in both modes, with no carry between fields.
  - Pause edges are ignored.
- **Pause edge (`sel_adj`=0):** toggles `running` and clears `done`. In `MODE`=1 with the time at 00:00, `running` stays 0.
- **`sec_tick` with `running`=1:**
  - `MODE`=0: BCD increment. 59 s carries into minutes; `MAX_MIN`:59 wraps to 00:00.
  - `MODE`=1: BCD decrement. 00 s borrows from minutes (59 s). A tick that produces 00:00 also sets `running`=0 and `done`=1 in the same cycle.
- **Display:**
  - The digit index advances 0→1→2→3→0 every `CLK_HZ/SCAN_HZ` cycles.
  - `an` is active-low one-hot on the current index.
  - `seg` is the active-low pattern for that digit. Examples: 0=1000000 is not used; 0=0000001 and 1=1001111 in the a..g order.
  - When `sel_adj`=1 and `blink`=1, both digits of the selected field show `seg`=1111111.
  - `dp`=0 only in the digit-2 slot.
- **Output registration:** `an`, `seg` and `dp` are registered.

## Timing
- **Reset values:**
  - `an`=1111, `seg`=1111111, `dp`=1.
  - `running`=0, `done`=0, `min_bcd`=00, `sec_bcd`=00.
  - All counters, synchronisers and `blink` are 0.
- **Reset assertion and release:**
  - Reset takes effect immediately on assertion, including mid-count or mid-adjust.
  - The first display update occurs on the first `clk` edge after release: `an`=1110, `seg`=0000001.
- **Button latency:** a button rising edge changes state on the 3rd rising `clk` edge after the input rises. A pulse narrower than one cycle is not guaranteed to register.
- **Tick timing:**
  - The first `sec_tick` comes exactly `CLK_HZ` cycles after the cycle in which the clear edge is applied. Thereafter `sec_tick` recurs every `CLK_HZ` cycles.
  - Without a clear, the first tick arrives 1..`CLK_HZ` cycles after the run toggle (free-running prescaler).
- **Output latency:** `min_bcd` and `sec_bcd` update in the tick cycle, i.e. on the edge where the tick is high. The display reflects the change at the next slot boundary.
- **Simultaneous events:**
  - A `sec_tick` coinciding with a pause edge uses the pre-toggle `running` value.
  - An `adj_tick` while `sel_adj` drops in the same cycle is not applied.

## Test plan
Benches use `CLK_HZ`=8 and `SCAN_HZ`=4 (2 cycles per digit).

1. **Count-up carry:** `MODE`=0, `MAX_MIN`=59. Reset, clear edge, pause edge, then 60·8 cycles → `min_bcd`=01, `sec_bcd`=00, `running`=1.
2. **Count-up wrap:** `MAX_MIN`=1. Run from 00:00 for 120 s → 00:00. At 119 s → `min_bcd`=01, `sec_bcd`=59.
3. **Adjust seconds:**
   - Setup: `sel_adj`=1, `adj_field`=0 for 16 cycles while `running`=1.
   - Expected: `sec_bcd` +4, minutes unchanged.
   - Display: `seg`=1111111 in the `an[1]`/`an[0]` slots while `blink`=1; the minutes digits show normally.
4. **Count-down expiry:** `MODE`=1. Adjust to 00:03, then pause edge. After 24 cycles → 00:00, `done`=1, `running`=0. A further pause edge leaves `running`=0 and sets `done`=0.
5. **Clear/pause collision:** clear and pause edges in the same cycle at 00:05 running → 00:00, `running`=0. The next `sec_tick` occurs exactly 8 cycles later.
6. **Async reset:** assert `reset`=0 mid-count at 00:42 → all outputs at their reset values without a clock edge. After release, the first edge gives `an`=1110.

Source files
------------

// File: rtl/clock_sim_core.sv
// clock_sim_core: MM:SS clock/timer with count-up or count-down, run/pause,
// clear, field adjust with a blinking selected field, and a multiplexed
// 4-digit active-low seven-segment driver. Single clock domain; all timing
// is derived from tick enables.
//
// Ports:
//   clk, reset        system clock, asynchronous active-low reset
//   btn_pause         debounced level, rising edge toggles run
//   btn_clear         debounced level, rising edge clears to 00:00
//   sel_adj           1 = adjust mode
//   adj_field         0 = adjust seconds, 1 = adjust minutes
//   an[3:0]           digit enables, active-low, an[3] = minutes tens
//   seg[6:0]          segments a..g (seg[6] = a), active-low
//   dp                decimal point, active-low, lit in digit-2 slot only
//   running, done     run flag, count-down expired flag
//   min_bcd, sec_bcd  current time in BCD, tens in [7:4]
module clock_sim_core #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000,
  parameter int MAX_MIN = 59,
  parameter int MODE    = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_pause,
  input  logic       btn_clear,
  input  logic       sel_adj,
  input  logic       adj_field,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       running,
  output logic       done,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd
);

  localparam int QDIV = CLK_HZ / 4;
  localparam int SDIV = CLK_HZ / SCAN_HZ;
  localparam int PW   = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam int SW   = (SDIV > 1) ? $clog2(SDIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(QDIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SDIV - 1);
  localparam logic [7:0]    MAX_BCD   = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

  // BCD +1 that wraps to 00 after 'last'
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // BCD -1 that wraps from 00 to 'last'
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] last);
    if (v == 8'h00) return last;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  logic [1:0]    pause_sync_q, pause_sync_d, clear_sync_q, clear_sync_d;
  logic          pause_prev_q, pause_prev_d, clear_prev_q, clear_prev_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    phase_q, phase_d;
  logic          blink_q, blink_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    dig_q, dig_d;
  logic          running_q, running_d, done_q, done_d;
  logic [7:0]    min_q, min_d, sec_q, sec_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic pause_edge, clear_edge, q_tick, sec_tick, adj_tick, time_zero, blank;
  logic [3:0] digit;

  assign pause_edge = pause_sync_q[1] & ~pause_prev_q;
  assign clear_edge = clear_sync_q[1] & ~clear_prev_q;
  assign q_tick     = (presc_q == PRE_LAST);
  assign sec_tick   = q_tick & (phase_q == 2'd3);
  assign adj_tick   = q_tick & phase_q[0];
  assign time_zero  = (min_q == 8'h00) && (sec_q == 8'h00);

  always_comb begin : in_cond
    pause_sync_d = {pause_sync_q[0], btn_pause};
    pause_prev_d = pause_sync_q[1];
    clear_sync_d = {clear_sync_q[0], btn_clear};
    clear_prev_d = clear_sync_q[1];
  end

  // Clear realigns the prescaler so the next second lands a full period later
  always_comb begin : ticks
    if (clear_edge) begin
      presc_d = '0;
      phase_d = 2'd0;
      blink_d = 1'b0;
    end else begin
      presc_d = q_tick ? '0 : presc_q + PW'(1);
      phase_d = phase_q + {1'b0, q_tick};
      blink_d = blink_q ^ q_tick;
    end
  end

  // Priority: clear, adjust, pause/second tick. A tick in the same cycle as a
  // pause edge uses the pre-toggle run flag; an expiring tick wins over pause.
  always_comb begin : time_next
    min_d     = min_q;
    sec_d     = sec_q;
    running_d = running_q;
    done_d    = done_q;
    if (clear_edge) begin
      min_d     = 8'h00;
      sec_d     = 8'h00;
      running_d = 1'b0;
      done_d    = 1'b0;
    end else if (sel_adj) begin
      if (adj_tick) begin
        if (adj_field) min_d = bcd_inc(min_q, MAX_BCD);
        else           sec_d = bcd_inc(sec_q, 8'h59);
      end
    end else begin
      if (pause_edge) begin
        running_d = (MODE == 1 && time_zero) ? 1'b0 : ~running_q;
        done_d    = 1'b0;
      end
      if (running_q && sec_tick) begin
        if (MODE == 0) begin
          sec_d = bcd_inc(sec_q, 8'h59);
          if (sec_q == 8'h59) min_d = bcd_inc(min_q, MAX_BCD);
        end else begin
          sec_d = bcd_dec(sec_q, 8'h59);
          if (sec_q == 8'h00) min_d = bcd_dec(min_q, MAX_BCD);
          if (sec_d == 8'h00 && min_d == 8'h00) begin
            running_d = 1'b0;
            done_d    = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin : digit_sel
    case (dig_q)
      2'd0:    digit = sec_q[3:0];
      2'd1:    digit = sec_q[7:4];
      2'd2:    digit = min_q[3:0];
      default: digit = min_q[7:4];
    endcase
    blank = sel_adj & blink_q & (dig_q[1] == adj_field);
  end

  // Display registers load once per slot, at the slot's first cycle
  always_comb begin : display
    scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + SW'(1);
    dig_d  = dig_q + {1'b0, (scan_q == SCAN_LAST)};
    an_d   = an_q;
    seg_d  = seg_q;
    dp_d   = dp_q;
    if (scan_q == '0) begin
      an_d  = ~(4'b0001 << dig_q);
      seg_d = blank ? 7'b1111111 : seg7(digit);
      dp_d  = (dig_q != 2'd2);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pause_sync_q <= 2'b00;
      pause_prev_q <= 1'b0;
      clear_sync_q <= 2'b00;
      clear_prev_q <= 1'b0;
      presc_q      <= '0;
      phase_q      <= 2'd0;
      blink_q      <= 1'b0;
      scan_q       <= '0;
      dig_q        <= 2'd0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      min_q        <= 8'h00;
      sec_q        <= 8'h00;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
    end else begin
      pause_sync_q <= pause_sync_d;
      pause_prev_q <= pause_prev_d;
      clear_sync_q <= clear_sync_d;
      clear_prev_q <= clear_prev_d;
      presc_q      <= presc_d;
      phase_q      <= phase_d;
      blink_q      <= blink_d;
      scan_q       <= scan_d;
      dig_q        <= dig_d;
      running_q    <= running_d;
      done_q       <= done_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an      = an_q;
  assign seg     = seg_q;
  assign dp      = dp_q;
  assign running = running_q;
  assign done    = done_q;
  assign min_bcd = min_q;
  assign sec_bcd = sec_q;

endmodule

// File: tb/tb_clock_sim_core.sv
// Bench for clock_sim_core: a count-up instance (MAX_MIN=1) and a count-down
// instance (MAX_MIN=59) share stimulus; each is compared against a
// behavioural model that keeps time as a plain seconds count.
module tb_clock_sim_core;
  localparam int CLK_HZ  = 8;
  localparam int SCAN_HZ = 4;
  localparam int Q       = CLK_HZ / 4;
  localparam int SLOT    = CLK_HZ / SCAN_HZ;
  localparam logic [29:0] RST_VEC = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0, 16'h0000};

  logic clk = 0, reset = 1;
  logic btn_pause = 0, btn_clear = 0, sel_adj = 0, adj_field = 0;
  logic [3:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic dp0, dp1, run0, run1, done0, done1;
  logic [7:0] min0, min1, sec0, sec1;
  logic [29:0] obs0, obs1;
  int n_cmp = 0, n_err = 0;

  assign obs0 = {an0, seg0, dp0, run0, done0, min0, sec0};
  assign obs1 = {an1, seg1, dp1, run1, done1, min1, sec1};

  clock_sim_core #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .MAX_MIN(1), .MODE(0)) u_up (
    .clk(clk), .reset(reset), .btn_pause(btn_pause), .btn_clear(btn_clear),
    .sel_adj(sel_adj), .adj_field(adj_field), .an(an0), .seg(seg0), .dp(dp0),
    .running(run0), .done(done0), .min_bcd(min0), .sec_bcd(sec0));

  clock_sim_core #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .MAX_MIN(59), .MODE(1)) u_dn (
    .clk(clk), .reset(reset), .btn_pause(btn_pause), .btn_clear(btn_clear),
    .sel_adj(sel_adj), .adj_field(adj_field), .an(an1), .seg(seg1), .dp(dp1),
    .running(run1), .done(done1), .min_bcd(min1), .sec_bcd(sec1));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int mt[2];                 // time in seconds
  bit mrun[2], mdone[2];
  logic [3:0] man[2];
  logic [6:0] mseg[2];
  logic mdp[2];
  int mc, msc;               // cycles since clear (mod CLK_HZ), cycles since reset
  bit [3:1] ph, ch;          // button samples from the last three edges

  function automatic int mmax(int i);  return (i == 0) ? 1 : 59; endfunction
  function automatic int mmode(int i); return (i == 0) ? 0 : 1;  endfunction

  function automatic logic [6:0] seg_of(int d);
    case (d)
      0: return 7'b0000001; 1: return 7'b1001111; 2: return 7'b0010010;
      3: return 7'b0000110; 4: return 7'b1001100; 5: return 7'b0100100;
      6: return 7'b0100000; 7: return 7'b0001111; 8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [29:0] exp_vec(int i);
    return {man[i], mseg[i], mdp[i], mrun[i], mdone[i], to_bcd(mt[i] / 60), to_bcd(mt[i] % 60)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mt[i] = 0; mrun[i] = 0; mdone[i] = 0;
      man[i] = 4'hF; mseg[i] = 7'h7F; mdp[i] = 1'b1;
    end
    mc = 0; msc = 0; ph = '0; ch = '0;
  endtask

  task automatic model_edge();
    bit pe, ce, qt, st, at, bl, nr, blank;
    int d, dv, s, m, n;
    if (!reset) begin
      model_reset();
      return;
    end
    pe = ph[2] && !ph[3];
    ce = ch[2] && !ch[3];
    qt = (mc % Q) == Q - 1;
    st = (mc == CLK_HZ - 1);
    at = qt && ((mc / Q) % 2 == 1);
    bl = ((mc / Q) % 2) == 1;
    for (int i = 0; i < 2; i++) begin
      if (msc % SLOT == 0) begin
        d = (msc / SLOT) % 4;
        s = mt[i] % 60;
        m = mt[i] / 60;
        case (d)
          0: dv = s % 10;
          1: dv = s / 10;
          2: dv = m % 10;
          default: dv = m / 10;
        endcase
        blank = sel_adj && bl && ((d >= 2) == adj_field);
        man[i]  = ~(4'b0001 << d);
        mseg[i] = blank ? 7'h7F : seg_of(dv);
        mdp[i]  = (d != 2);
      end
      n = (mmax(i) + 1) * 60;
      if (ce) begin
        mt[i] = 0; mrun[i] = 0; mdone[i] = 0;
      end else if (sel_adj) begin
        if (at) begin
          s = mt[i] % 60;
          m = mt[i] / 60;
          if (adj_field) m = (m + 1) % (mmax(i) + 1);
          else           s = (s + 1) % 60;
          mt[i] = m * 60 + s;
        end
      end else begin
        nr = mrun[i];
        if (pe) begin
          nr = (mmode(i) == 1 && mt[i] == 0) ? 1'b0 : !mrun[i];
          mdone[i] = 0;
        end
        if (mrun[i] && st) begin
          if (mmode(i) == 0) mt[i] = (mt[i] + 1) % n;
          else begin
            mt[i] = (mt[i] + n - 1) % n;
            if (mt[i] == 0) begin nr = 0; mdone[i] = 1; end
          end
        end
        mrun[i] = nr;
      end
    end
    msc++;
    mc = ce ? 0 : (mc + 1) % CLK_HZ;
    ph = {ph[2:1], btn_pause};
    ch = {ch[2:1], btn_clear};
  endtask

  // Advance one clock: model sees the same pre-edge inputs as the DUT
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic press_clear();
    btn_clear = 1;
    repeat (3) step();
    btn_clear = 0;
  endtask

  task automatic press_pause();
    btn_pause = 1;
    repeat (3) step();
    btn_pause = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 reset = 0;
    model_reset();
    #1;
    n_cmp++; if (obs0 !== RST_VEC) begin n_err++; $display("FAIL reset_up got %h want %h", obs0, RST_VEC); end
    n_cmp++; if (obs1 !== RST_VEC) begin n_err++; $display("FAIL reset_dn got %h want %h", obs1, RST_VEC); end
    step(); step();
    n_cmp++; if (obs0 !== RST_VEC) begin n_err++; $display("FAIL reset_held got %h want %h", obs0, RST_VEC); end
    reset = 1;
    step();
    n_cmp++; if (an0 !== 4'b1110 || seg0 !== 7'b0000001) begin
      n_err++; $display("FAIL first_disp got an=%b seg=%b want an=1110 seg=0000001", an0, seg0); end
    n_cmp++; if (obs1 !== exp_vec(1)) begin n_err++; $display("FAIL first_disp_dn got %h want %h", obs1, exp_vec(1)); end
  endtask

  task automatic test_count_up();
    press_clear();
    btn_pause = 1;
    for (int k = 1; k <= 960; k++) begin
      step();
      if (k == 3) btn_pause = 0;
      n_cmp++; if (obs0 !== exp_vec(0)) begin n_err++; $display("FAIL up_cycle k=%0d got %h want %h", k, obs0, exp_vec(0)); end
      n_cmp++; if (obs1 !== exp_vec(1)) begin n_err++; $display("FAIL dn_cycle k=%0d got %h want %h", k, obs1, exp_vec(1)); end
      if (k == 480) begin
        n_cmp++; if ({min0, sec0, run0} !== {8'h01, 8'h00, 1'b1}) begin
          n_err++; $display("FAIL carry got %h:%h run=%b want 01:00 run=1", min0, sec0, run0); end
        n_cmp++; if (run1 !== 1'b0) begin n_err++; $display("FAIL dn_zero_pause got run=%b want 0", run1); end
      end
      if (k == 952) begin
        n_cmp++; if ({min0, sec0} !== 16'h0159) begin n_err++; $display("FAIL pre_wrap got %h:%h want 01:59", min0, sec0); end
      end
      if (k == 960) begin
        n_cmp++; if ({min0, sec0, run0} !== {16'h0000, 1'b1}) begin
          n_err++; $display("FAIL wrap got %h:%h run=%b want 00:00 run=1", min0, sec0, run0); end
      end
    end
  endtask

  task automatic test_adjust_sec();
    int bs, bm;
    bit sec_blank, min_blank;
    bs = mt[0] % 60; bm = mt[0] / 60;
    sec_blank = 0; min_blank = 0;
    sel_adj = 1; adj_field = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      n_cmp++; if (obs0 !== exp_vec(0)) begin n_err++; $display("FAIL adj_cycle k=%0d got %h want %h", k, obs0, exp_vec(0)); end
      if (seg0 === 7'h7F && an0[1:0] != 2'b11) sec_blank = 1;
      if (seg0 === 7'h7F && an0[3:2] != 2'b11) min_blank = 1;
    end
    sel_adj = 0;
    n_cmp++; if (sec0 !== to_bcd((bs + 4) % 60) || min0 !== to_bcd(bm)) begin
      n_err++; $display("FAIL adj_sec got %h:%h want %h:%h", min0, sec0, to_bcd(bm), to_bcd((bs + 4) % 60)); end
    n_cmp++; if (sec_blank !== 1'b1) begin n_err++; $display("FAIL adj_blink got sec_blank=%b want 1", sec_blank); end
    n_cmp++; if (min_blank !== 1'b0) begin n_err++; $display("FAIL adj_min_shown got min_blank=%b want 0", min_blank); end
  endtask

  task automatic test_countdown();
    press_clear();
    sel_adj = 1; adj_field = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_cmp++; if (obs1 !== exp_vec(1)) begin n_err++; $display("FAIL cd_adj k=%0d got %h want %h", k, obs1, exp_vec(1)); end
    end
    sel_adj = 0;
    n_cmp++; if ({min1, sec1} !== 16'h0003) begin n_err++; $display("FAIL cd_set got %h:%h want 00:03", min1, sec1); end
    press_pause();
    n_cmp++; if (run1 !== 1'b1) begin n_err++; $display("FAIL cd_start got run=%b want 1", run1); end
    repeat (16) step();
    n_cmp++; if ({min1, sec1, done1, run1} !== {16'h0001, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL cd_last got %h:%h done=%b run=%b want 00:01 done=0 run=1", min1, sec1, done1, run1); end
    step();
    n_cmp++; if ({min1, sec1, done1, run1} !== {16'h0000, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL cd_expire got %h:%h done=%b run=%b want 00:00 done=1 run=0", min1, sec1, done1, run1); end
    press_pause();
    n_cmp++; if ({done1, run1} !== 2'b00) begin
      n_err++; $display("FAIL cd_repause got done=%b run=%b want 0 0", done1, run1); end
    n_cmp++; if (obs0 !== exp_vec(0)) begin n_err++; $display("FAIL cd_up_side got %h want %h", obs0, exp_vec(0)); end
  endtask

  task automatic test_collision();
    press_clear();
    press_pause();
    repeat (37) step();
    n_cmp++; if ({sec0, run0} !== {8'h05, 1'b1}) begin n_err++; $display("FAIL coll_pre got sec=%h run=%b want 05 1", sec0, run0); end
    btn_clear = 1; btn_pause = 1;
    repeat (3) step();
    n_cmp++; if ({min0, sec0, run0, run1} !== {16'h0000, 2'b00}) begin
      n_err++; $display("FAIL coll got %h:%h run=%b/%b want 00:00 run=0/0", min0, sec0, run0, run1); end
    btn_clear = 0; btn_pause = 0;
    step();
    btn_pause = 1;
    repeat (3) step();
    btn_pause = 0;
    n_cmp++; if (run0 !== 1'b1) begin n_err++; $display("FAIL coll_restart got run=%b want 1", run0); end
    repeat (3) step();
    n_cmp++; if (sec0 !== 8'h00) begin n_err++; $display("FAIL coll_tick7 got sec=%h want 00", sec0); end
    step();
    n_cmp++; if (sec0 !== 8'h01) begin n_err++; $display("FAIL coll_tick8 got sec=%h want 01", sec0); end
  endtask

  task automatic test_async_reset();
    repeat (328) step();
    n_cmp++; if ({min0, sec0, run0} !== {16'h0042, 1'b1}) begin
      n_err++; $display("FAIL ar_pre got %h:%h run=%b want 00:42 run=1", min0, sec0, run0); end
    #2 reset = 0;
    model_reset();
    #1;
    n_cmp++; if (obs0 !== RST_VEC) begin n_err++; $display("FAIL ar_up got %h want %h", obs0, RST_VEC); end
    n_cmp++; if (obs1 !== RST_VEC) begin n_err++; $display("FAIL ar_dn got %h want %h", obs1, RST_VEC); end
    step();
    reset = 1;
    step();
    n_cmp++; if (an0 !== 4'b1110 || seg0 !== 7'b0000001) begin
      n_err++; $display("FAIL ar_release got an=%b seg=%b want 1110 0000001", an0, seg0); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0)  btn_pause = ~btn_pause;
      if ($urandom_range(0, 39) == 0) btn_clear = ~btn_clear;
      if ($urandom_range(0, 29) == 0) sel_adj   = ~sel_adj;
      if ($urandom_range(0, 15) == 0) adj_field = ~adj_field;
      step();
      n_cmp++; if (obs0 !== exp_vec(0)) begin n_err++; $display("FAIL rand_up k=%0d got %h want %h", k, obs0, exp_vec(0)); end
      n_cmp++; if (obs1 !== exp_vec(1)) begin n_err++; $display("FAIL rand_dn k=%0d got %h want %h", k, obs1, exp_vec(1)); end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_adjust_sec();
    test_countdown();
    test_collision();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
